// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction memory,
// tracks the PC of every outstanding request and buffers returned words in a
// small prefetch FIFO that decode drains through a valid/ready port. A redirect
// empties the FIFO and marks the responses still in flight as stale so they are
// dropped when they come back.
module instr_fetch_unit #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   // count + inflight must stay strictly below this before a new request goes out
   localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] stale_q, stale_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] tag_wr_q, tag_wr_d;
   logic [PW-1:0] tag_rd_q, tag_rd_d;

   // Prefetch FIFO payload and the in-order queue of outstanding request PCs.
   logic [31:0] fifo_pc_mem    [DEPTH];
   logic [31:0] fifo_instr_mem [DEPTH];
   logic [31:0] tag_mem        [DEPTH];

   logic credit_ok;
   logic req_fire;
   logic rsp_take;
   logic rsp_drop;
   logic push;
   logic pop;

   // Outstanding requests still hold their credit even when stale, so the FIFO
   // can always absorb every response that is not dropped.
   assign credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < CREDIT_LIMIT;

   assign imem_req_valid = !reset && !redirect && credit_ok;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign rsp_take = imem_rsp_valid && (inflight_q != '0);
   // A response arriving in the redirect cycle belongs to the old path as well.
   assign rsp_drop = rsp_take && (redirect || (stale_q != '0));
   assign push     = rsp_take && !rsp_drop;
   assign pop      = out_valid && out_ready && !redirect;

   assign out_valid = (count_q != '0);
   assign out_pc    = out_valid ? fifo_pc_mem[rd_ptr_q] : 32'h0000_0000;
   assign out_instr = out_valid ? fifo_instr_mem[rd_ptr_q] : NOP_INSTR;

   // Next-state computation for PC, credit counters and queue pointers.
   always_comb begin
      pc_d       = pc_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      stale_d    = stale_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      tag_wr_d   = tag_wr_q;
      tag_rd_d   = tag_rd_q;

      if (req_fire) begin
         pc_d     = pc_q + 32'd4;
         tag_wr_d = tag_wr_q + PW'(1);
      end

      // Every accepted response retires its tag, stale or not.
      if (rsp_take) begin
         tag_rd_d = tag_rd_q + PW'(1);
      end

      case ({req_fire, rsp_take})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase

      if (redirect) begin
         pc_d     = {redirect_pc[31:2], 2'b00};
         stale_d  = rsp_take ? (inflight_q - CW'(1)) : inflight_q;
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (rsp_take && (stale_q != '0)) begin
            stale_d = stale_q - CW'(1);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         count_q    <= '0;
         inflight_q <= '0;
         stale_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tag_wr_q   <= '0;
         tag_rd_q   <= '0;
      end else begin
         pc_q       <= pc_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         stale_q    <= stale_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         tag_wr_q   <= tag_wr_d;
         tag_rd_q   <= tag_rd_d;
      end
   end

   // Storage writes: request PC into the tag queue, returned word into the FIFO.
   always_ff @(posedge clock) begin
      if (!reset && req_fire) begin
         tag_mem[tag_wr_q] <= pc_q;
      end
      if (!reset && push) begin
         fifo_pc_mem[wr_ptr_q]    <= tag_mem[tag_rd_q];
         fifo_instr_mem[wr_ptr_q] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: an in-order memory model with configurable latency,
// a request-side monitor that records what decode should eventually receive, and
// an output-side monitor that pops and compares. Directed phases follow the
// listed scenarios, then a randomized phase mixes stalls, redirects and resets.
module tb_instr_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clock;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   instr_fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC),
      .NOP_INSTR(NOP)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr (imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_instr     (out_instr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   int pop_cnt = 0;
   int accept_cnt = 0;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %08h, wanted %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Instruction memory contents as a pure function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ (a << 3) ^ 32'hC0DE_0073;
   endfunction

   // ---------------- memory model ----------------
   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;
   mreq_t mem_q[$];
   int    cyc = 0;
   int    last_due = 0;
   int    lat_max = 1;
   bit    lat_rand = 1'b0;
   bit    spurious_en = 1'b0;
   int    lat_v;
   int    due_v;

   always @(negedge clock) begin
      cyc++;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mem_q[0].addr);
         void'(mem_q.pop_front());
      end else if (spurious_en && mem_q.size() == 0 && $urandom_range(0, 3) == 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = $urandom;
      end
      #1;
      if (reset) begin
         mem_q.delete();
         last_due = 0;
      end else if (imem_req_valid && imem_req_ready) begin
         lat_v = lat_rand ? int'($urandom_range(1, lat_max)) : lat_max;
         due_v = cyc + lat_v;
         if (due_v <= last_due) due_v = last_due + 1;
         last_due = due_v;
         mem_q.push_back('{imem_req_addr, due_v});
         accept_cnt++;
      end
   end

   // ---------------- request monitor: fills the scoreboard ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   exp_t        exp_q[$];
   logic [31:0] req_exp_pc = RESET_PC;

   always @(negedge clock) begin
      #2;
      if (reset) begin
         check(!imem_req_valid, "req_valid_in_reset", 32'(imem_req_valid), 32'h0);
         exp_q.delete();
         req_exp_pc = RESET_PC;
      end else if (redirect) begin
         check(!imem_req_valid, "req_valid_in_redirect", 32'(imem_req_valid), 32'h0);
         exp_q.delete();
         req_exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (imem_req_valid && imem_req_ready) begin
         check(imem_req_addr == req_exp_pc, "req_addr", imem_req_addr, req_exp_pc);
         exp_q.push_back('{req_exp_pc, mem_word(req_exp_pc)});
         req_exp_pc = req_exp_pc + 32'd4;
         check(exp_q.size() <= DEPTH, "credit_fifo", 32'(exp_q.size()), 32'(DEPTH));
         check(mem_q.size() <= DEPTH, "credit_inflight", 32'(mem_q.size()), 32'(DEPTH));
      end
   end

   // ---------------- output monitor: pops and compares ----------------
   exp_t e;
   always @(negedge clock) begin
      #3;
      if (!reset) begin
         if (!out_valid) begin
            check(out_instr == NOP, "empty_nop", out_instr, NOP);
         end else if (out_ready && !redirect) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_output", out_pc, 32'h0);
            end else begin
               e = exp_q.pop_front();
               check(out_pc == e.pc, "out_pc", out_pc, e.pc);
               check(out_instr == e.instr, "out_instr", out_instr, e.instr);
               pop_cnt++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clock);
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      tick();
      redirect    = 1'b1;
      redirect_pc = pc;
      tick();
      redirect    = 1'b0;
   endtask

   task automatic wait_inflight(input int n);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         tick();
         #4;
         if (mem_q.size() >= n) hit = 1'b1;
      end
      check(hit, "inflight_build", 32'(mem_q.size()), 32'(n));
   endtask

   int p0;
   int a0;

   initial begin
      reset          = 1'b1;
      redirect       = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;
      imem_req_ready = 1'b0;

      // Reset state
      repeat (3) tick();
      #4;
      check(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'h0);
      check(out_pc == 32'h0, "rst_out_pc", out_pc, 32'h0);
      check(out_instr == NOP, "rst_out_instr", out_instr, NOP);
      check(imem_req_valid == 1'b0, "rst_req_valid", 32'(imem_req_valid), 32'h0);

      // 1: streaming, one instruction per cycle
      tick();
      reset          = 1'b0;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      #4;
      check(imem_req_valid == 1'b1, "t1_req_valid", 32'(imem_req_valid), 32'h1);
      check(imem_req_addr == RESET_PC, "t1_first_addr", imem_req_addr, RESET_PC);
      repeat (4) tick();
      #4;
      p0 = pop_cnt;
      repeat (16) tick();
      #4;
      check(pop_cnt - p0 == 16, "t1_throughput", 32'(pop_cnt - p0), 32'd16);

      // 2: decode stall fills exactly DEPTH entries
      tick();
      reset     = 1'b1;
      out_ready = 1'b0;
      tick();
      reset = 1'b0;
      a0    = accept_cnt;
      repeat (12) tick();
      #4;
      check(accept_cnt - a0 == DEPTH, "t2_accepts", 32'(accept_cnt - a0), 32'(DEPTH));
      check(imem_req_valid == 1'b0, "t2_req_low", 32'(imem_req_valid), 32'h0);
      check(out_valid == 1'b1, "t2_out_valid", 32'(out_valid), 32'h1);
      check(out_pc == 32'h0, "t2_head_pc", out_pc, 32'h0);
      tick();
      out_ready = 1'b1;
      p0 = pop_cnt;
      repeat (10) tick();
      #4;
      check(pop_cnt - p0 >= 5, "t2_release", 32'(pop_cnt - p0), 32'd5);

      // 3: redirect with several responses in flight at 3-cycle latency
      lat_max = 3;
      do_reset();
      wait_inflight(2);
      do_redirect(32'h0000_0100);
      #4;
      check(imem_req_addr == 32'h0000_0100, "t3_redir_addr", imem_req_addr, 32'h100);
      p0 = pop_cnt;
      for (int i = 0; i < 20 && pop_cnt == p0; i++) tick();
      check(pop_cnt > p0, "t3_resume", 32'(pop_cnt - p0), 32'd1);

      // 4: redirect colliding with a response and a pop
      lat_max = 1;
      repeat (8) tick();
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0040;
      #4;
      check(out_valid && imem_rsp_valid, "t4_collision_setup", 32'({out_valid, imem_rsp_valid}), 32'h3);
      tick();
      redirect = 1'b0;
      #4;
      check(out_valid == 1'b0, "t4_flushed", 32'(out_valid), 32'h0);
      check(out_instr == NOP, "t4_nop", out_instr, NOP);

      // 5: redirect alignment and PC wrap
      do_redirect(32'h0000_0203);
      #4;
      check(imem_req_addr == 32'h0000_0200, "t5_align", imem_req_addr, 32'h200);
      repeat (10) tick();
      do_redirect(32'hFFFF_FFF4);
      #4;
      check(imem_req_addr == 32'hFFFF_FFF4, "t5_high_addr", imem_req_addr, 32'hFFFF_FFF4);
      p0 = pop_cnt;
      repeat (15) tick();
      #4;
      check(pop_cnt - p0 >= 6, "t5_wrap_stream", 32'(pop_cnt - p0), 32'd6);

      // 6: reset in the middle of a burst
      lat_max = 3;
      wait_inflight(2);
      do_reset();
      #4;
      check(out_valid == 1'b0, "t6_out_valid", 32'(out_valid), 32'h0);
      check(out_pc == 32'h0, "t6_out_pc", out_pc, 32'h0);
      check(imem_req_addr == RESET_PC, "t6_req_addr", imem_req_addr, RESET_PC);
      repeat (20) tick();

      // Randomized mix
      lat_rand    = 1'b1;
      lat_max     = 5;
      spurious_en = 1'b1;
      p0 = pop_cnt;
      for (int i = 0; i < 1500; i++) begin
         tick();
         imem_req_ready = ($urandom_range(0, 3) != 0);
         out_ready      = ($urandom_range(0, 2) != 0);
         redirect       = ($urandom_range(0, 24) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                      : $urandom;
         reset          = ($urandom_range(0, 299) == 0);
      end
      tick();
      redirect       = 1'b0;
      reset          = 1'b0;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      repeat (40) tick();
      #4;
      check(pop_cnt - p0 >= 200, "random_liveness", 32'(pop_cnt - p0), 32'd200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
